onehot_rr_arbiter: RTL and testbench

- Round-robin arbiter over N requesters, with a grant that is held until the requester releases it.
- The grant is a registered one-hot vector. It feeds the downstream one-hot-to-index encoder, which turns it into a 3-bit bit position.
- The block guarantees that the grant is either all-zero or exactly one bit set, so the encoder never sees an illegal multi-hot code.

---
 rtl/onehot_rr_arbiter.sv | 149 ++++++++++++++
 tb/tb_onehot_rr_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with a held, registered one-hot grant and rotating priority pointer.
// Optional grant hold timeout is compiled in with `define RR_ARB_TIMEOUT_EN.
module onehot_rr_arbiter #(
   parameter int unsigned N       = 8,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         done,
   output logic [N-1:0] grant,
`ifdef RR_ARB_TIMEOUT_EN
   output logic         timeout,
`endif
   output logic         grant_valid
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_e;

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   state_e       state_q, state_d;
   logic [N-1:0] grant_q, grant_d;
   logic [2:0]   ptr_q,   ptr_d;

   logic [N-1:0] cand;
   logic [2:0]   win;
   logic         release_grant;
   logic         expire;
   logic         new_grant;

   // Rotate the request so ptr lands on bit 0, take the lowest set bit, rotate the index back.
   function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [15:0] dbl;
      logic [7:0]  rot;
      logic [2:0]  k;
      logic        hit;
      dbl = {r, r} >> p;
      rot = dbl[7:0];
      k   = 3'd0;
      hit = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (!hit && rot[i]) begin
            k   = 3'(i);
            hit = 1'b1;
         end
      end
      return p + k;
   endfunction

`ifdef RR_ARB_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       timeout_q, timeout_d;

   assign expire = (state_q == S_GRANT) && !done && (cnt_q == 8'(TIMEOUT - 1));
`else
   assign expire = 1'b0;
`endif

   assign release_grant = (state_q == S_GRANT) && (done || expire);

   // The releasing holder is masked so it cannot win back-to-back while others wait.
   assign cand = (state_q == S_IDLE) ? req : (req & ~grant_q);
   assign win  = rr_pick(cand, ptr_q);

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      new_grant = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|cand) begin
               new_grant = 1'b1;
            end
         end
         S_GRANT: begin
            if (release_grant) begin
               if (|cand) begin
                  new_grant = 1'b1;
               end else begin
                  grant_d = '0;
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
      endcase
      if (new_grant) begin
         grant_d = ONE << win;
         ptr_d   = win + 3'd1;
         state_d = S_GRANT;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         ptr_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef RR_ARB_TIMEOUT_EN
   always_comb begin
      cnt_d     = cnt_q;
      timeout_d = expire;
      if (new_grant) begin
         cnt_d = 8'd0;
      end else if (state_q == S_GRANT && !done) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`endif

   assign grant       = grant_q;
   assign grant_valid = |grant_q;

`ifndef SYNTHESIS
   a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
   a_state_grant : assert property (@(posedge clk) disable iff (!rst_n)
                                    ((state_q == S_GRANT) == (|grant_q)));
`endif

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Scoreboard bench for onehot_rr_arbiter: a behavioural model queues the expected grant per cycle.
// Define RR_ARB_TIMEOUT_EN to exercise the timeout build (TIMEOUT=4).
module tb_onehot_rr_arbiter;

   localparam int TB_TIMEOUT = 4;

   typedef struct {
      logic [7:0] grant;
      logic       to;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic       grant_valid;
   logic       timeout_o;

   int tests_run    = 0;
   int tests_failed = 0;

   exp_t exp_q[$];

   // Behavioural model state
   logic       m_busy;
   logic [7:0] m_grant;
   int         m_ptr;
   int         m_holder;
   int         m_cnt;
   logic       m_to;

`ifdef RR_ARB_TIMEOUT_EN
   onehot_rr_arbiter #(.N(8), .TIMEOUT(TB_TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .timeout     (timeout_o),
      .grant_valid (grant_valid)
   );
`else
   onehot_rr_arbiter #(.N(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_valid (grant_valid)
   );
   assign timeout_o = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_busy   = 1'b0;
      m_grant  = 8'h00;
      m_ptr    = 0;
      m_holder = 0;
      m_cnt    = 0;
      m_to     = 1'b0;
      exp_q.delete();
   endtask

   task automatic m_arbitrate(input logic [7:0] r);
      int found;
      found = -1;
      for (int k = 0; k < 8; k++) begin
         if (found < 0 && r[(m_ptr + k) % 8]) found = (m_ptr + k) % 8;
      end
      if (found >= 0) begin
         m_busy   = 1'b1;
         m_holder = found;
         m_grant  = 8'h00;
         m_grant[found] = 1'b1;
         m_ptr    = (found + 1) % 8;
         m_cnt    = 0;
      end else begin
         m_busy  = 1'b0;
         m_grant = 8'h00;
      end
   endtask

   task automatic model_step(input logic [7:0] r, input logic d);
      logic       expire;
      logic [7:0] masked;
      expire = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      expire = m_busy && !d && (m_cnt == TB_TIMEOUT - 1);
`endif
      m_to = expire;
      if (!m_busy) begin
         if (r != 8'h00) m_arbitrate(r);
      end else if (d || expire) begin
         masked = r;
         masked[m_holder] = 1'b0;
         m_arbitrate(masked);
      end else begin
         m_cnt++;
      end
   endtask

   // Drive one cycle of stimulus, queue the model's prediction, then compare after the edge.
   task automatic step(input logic [7:0] r, input logic d);
      exp_t e;
      @(negedge clk);
      req  = r;
      done = d;
      model_step(r, d);
      exp_q.push_back('{grant: m_grant, to: m_to});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("queue_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("grant", 32'(grant), 32'(e.grant));
         check("grant_valid", 32'(grant_valid), 32'(|e.grant));
         check("onehot0", 32'($onehot0(grant)), 32'd1);
`ifdef RR_ARB_TIMEOUT_EN
         check("timeout", 32'(timeout_o), 32'(e.to));
`endif
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      req   = 8'h00;
      done  = 1'b0;
      rst_n = 1'b0;
      m_reset();
      #1;
      check("rst_grant", 32'(grant), 32'h00);
      check("rst_valid", 32'(grant_valid), 32'd0);
      check("rst_timeout", 32'(timeout_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b1;
      req   = 8'h00;
      done  = 1'b0;
      m_reset();
      do_reset();

      // Idle with no requests
      for (int i = 0; i < 5; i++) step(8'h00, 1'b0);

      // Two requesters from ptr=0, then back-to-back handover on done
      step(8'h24, 1'b0);
      check("t2_first", 32'(grant), 32'h04);
      step(8'h24, 1'b1);
      check("t2_second", 32'(grant), 32'h20);
      step(8'h00, 1'b0);
      check("t2_hold_no_req", 32'(grant), 32'h20);
      step(8'h00, 1'b1);
      check("t2_idle", 32'(grant), 32'h00);

      // All requesting: full rotation including 80 -> 01 wrap
      do_reset();
      step(8'hFF, 1'b0);
      check("t3_start", 32'(grant), 32'h01);
      for (int i = 0; i < 8; i++) begin
         logic [7:0] want;
         want = 8'h01 << ((i + 1) % 8);
         step(8'hFF, 1'b0);
         step(8'hFF, 1'b1);
         check("t3_rot", 32'(grant), 32'(want));
      end

      // Sole requester: released to idle for one cycle, then re-granted
      step(8'h00, 1'b1);
      step(8'h10, 1'b0);
      check("t4_grant", 32'(grant), 32'h10);
      step(8'h10, 1'b1);
      check("t4_bubble", 32'(grant), 32'h00);
      step(8'h10, 1'b0);
      check("t4_regrant", 32'(grant), 32'h10);

      // Asynchronous reset while granted
      step(8'h00, 1'b1);
      step(8'h08, 1'b0);
      check("t5_pre", 32'(grant), 32'h08);
      #2;
      rst_n = 1'b0;
      req   = 8'h00;
      done  = 1'b0;
      m_reset();
      #1;
      check("t5_async_grant", 32'(grant), 32'h00);
      check("t5_async_valid", 32'(grant_valid), 32'd0);
      @(posedge clk);
      #1;
      check("t5_held", 32'(grant), 32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      step(8'h08, 1'b0);
      check("t5_after", 32'(grant), 32'h08);

`ifdef RR_ARB_TIMEOUT_EN
      // Forced release after TIMEOUT cycles with no done
      do_reset();
      step(8'h03, 1'b0);
      check("t6_g0", 32'(grant), 32'h01);
      for (int i = 0; i < TB_TIMEOUT - 1; i++) begin
         step(8'h03, 1'b0);
         check("t6_hold", 32'(grant), 32'h01);
         check("t6_no_to", 32'(timeout_o), 32'd0);
      end
      step(8'h03, 1'b0);
      check("t6_next", 32'(grant), 32'h02);
      check("t6_pulse", 32'(timeout_o), 32'd1);
      step(8'h03, 1'b0);
      check("t6_pulse_end", 32'(timeout_o), 32'd0);
`endif

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic [7:0] r;
         r = 8'($urandom);
         if ($urandom_range(0, 3) == 0) r = 8'h00;
         step(r, ($urandom_range(0, 2) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
